// File: rtl/eth_rx_frame_fifo_pkg.sv
// eth_rx_frame_fifo_pkg: shared ethernet types (command enums, RX write FSM states, stored beat layout)
package eth_rx_frame_fifo_pkg;

    localparam int eth_data_width_lp = 64;
    localparam int eth_keep_width_lp = eth_data_width_lp / 8;

    typedef enum logic [1:0] {e_rx_cmd_none, e_rx_cmd_enable, e_rx_cmd_flush} eth_rx_cmd_e;
    typedef enum logic [1:0] {e_tx_cmd_none, e_tx_cmd_send, e_tx_cmd_pause} eth_tx_cmd_e;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DROP} eth_rx_state_e;

    typedef struct packed {
        logic [eth_data_width_lp-1:0] data;
        logic [eth_keep_width_lp-1:0] keep;
        logic                         last;
    } eth_beat_s;

endpackage

// File: rtl/bsg_mem_1r1w.sv
// bsg_mem_1r1w: one synchronous write port, one asynchronous read port register file
module bsg_mem_1r1w #(
    parameter int width_p = 73,
    parameter int els_p   = 512
) (
    input  logic                     w_clk_i,
    input  logic                     w_v_i,
    input  logic [$clog2(els_p)-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic [$clog2(els_p)-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);

    logic [width_p-1:0] mem [els_p];

    always_ff @(posedge w_clk_i) begin
        if (w_v_i) mem[w_addr_i] <= w_data_i;
    end

    assign r_data_o = mem[r_addr_i];

endmodule

// File: rtl/eth_rx_frame_fifo.sv
// eth_rx_frame_fifo: store-and-forward RX frame buffer that releases only complete good frames
module eth_rx_frame_fifo
    import eth_rx_frame_fifo_pkg::*;
#(
    parameter int axis_data_width_p = 64,
    parameter int els_p             = 512,
    parameter int cnt_width_p       = 16
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic [axis_data_width_p-1:0]   s_axis_tdata_i,
    input  logic [axis_data_width_p/8-1:0] s_axis_tkeep_i,
    input  logic                           s_axis_tvalid_i,
    output logic                           s_axis_tready_o,
    input  logic                           s_axis_tlast_i,
    input  logic                           s_axis_tuser_i,
    output logic [axis_data_width_p-1:0]   m_axis_tdata_o,
    output logic [axis_data_width_p/8-1:0] m_axis_tkeep_o,
    output logic                           m_axis_tvalid_o,
    input  logic                           m_axis_tready_i,
    output logic                           m_axis_tlast_o,
    output logic                           m_axis_tuser_o,
    output logic [cnt_width_p-1:0]         good_frame_cnt_o,
    output logic [cnt_width_p-1:0]         drop_frame_cnt_o,
    output logic                           overflow_o
);

    localparam int aw_lp = $clog2(els_p);
    localparam int pw_lp = aw_lp + 1;

    logic [pw_lp-1:0] wr_q, wr_d, commit_q, commit_d, rd_q, rd_d;
    logic [cnt_width_p-1:0] good_q, good_d, drop_q, drop_d;
    eth_rx_state_e state_q, state_d;
    logic ovf_q, ovf_d, rdy_q, we, beat, full, empty, good_inc, drop_inc;
    eth_beat_s w_beat, r_beat;

    assign beat  = s_axis_tvalid_i & rdy_q;
    assign full  = (wr_q - rd_q) == pw_lp'(els_p);
    assign empty = rd_q == commit_q;
    assign w_beat = '{data: s_axis_tdata_i, keep: s_axis_tkeep_i, last: s_axis_tlast_i};

    // a bad or overflowing frame rewinds the write pointer to the last committed frame boundary
    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        commit_d = commit_q;
        we       = 1'b0;
        ovf_d    = 1'b0;
        good_inc = 1'b0;
        drop_inc = 1'b0;
        if (beat) begin
            if (state_q == S_DROP) begin
                state_d = s_axis_tlast_i ? S_IDLE : S_DROP;
            end else if (full) begin
                wr_d     = commit_q;
                ovf_d    = 1'b1;
                drop_inc = 1'b1;
                state_d  = s_axis_tlast_i ? S_IDLE : S_DROP;
            end else begin
                we       = 1'b1;
                wr_d     = (s_axis_tlast_i & s_axis_tuser_i) ? commit_q : wr_q + pw_lp'(1);
                commit_d = (s_axis_tlast_i & ~s_axis_tuser_i) ? wr_q + pw_lp'(1) : commit_q;
                good_inc = s_axis_tlast_i & ~s_axis_tuser_i;
                drop_inc = s_axis_tlast_i & s_axis_tuser_i;
                state_d  = s_axis_tlast_i ? S_IDLE : S_WRITE;
            end
        end
        rd_d   = rd_q + pw_lp'(m_axis_tvalid_o & m_axis_tready_i);
        good_d = (good_inc & ~&good_q) ? good_q + cnt_width_p'(1) : good_q;
        drop_d = (drop_inc & ~&drop_q) ? drop_q + cnt_width_p'(1) : drop_q;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= S_IDLE;
            wr_q     <= '0;
            commit_q <= '0;
            rd_q     <= '0;
            good_q   <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            commit_q <= commit_d;
            rd_q     <= rd_d;
            good_q   <= good_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
            rdy_q    <= 1'b1;
        end
    end

    bsg_mem_1r1w #(.width_p($bits(eth_beat_s)), .els_p(els_p)) mem (
        .w_clk_i (clk_i),
        .w_v_i   (we),
        .w_addr_i(wr_q[aw_lp-1:0]),
        .w_data_i(w_beat),
        .r_addr_i(rd_q[aw_lp-1:0]),
        .r_data_o(r_beat)
    );

    assign s_axis_tready_o  = rdy_q;
    assign m_axis_tdata_o   = r_beat.data;
    assign m_axis_tkeep_o   = r_beat.keep;
    assign m_axis_tlast_o   = r_beat.last;
    assign m_axis_tvalid_o  = ~empty;
    assign m_axis_tuser_o   = 1'b0;
    assign good_frame_cnt_o = good_q;
    assign drop_frame_cnt_o = drop_q;
    assign overflow_o       = ovf_q;

endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// tb_eth_rx_frame_fifo: directed scenarios for the RX frame FIFO with an 8-entry buffer and 4-bit counters
module tb_eth_rx_frame_fifo;
    import eth_rx_frame_fifo_pkg::*;

    logic clk = 1'b0, rst_n = 1'b1;
    logic [63:0] s_data = '0, m_data;
    logic [7:0] s_keep = '0, m_keep;
    logic s_valid = 1'b0, s_ready, s_last = 1'b0, s_user = 1'b0;
    logic m_valid, m_ready = 1'b0, m_last, m_user, ovf;
    logic [3:0] good, drop;

    int chk = 0, err = 0;
    eth_beat_s obs[$];
    eth_beat_s cur, held;
    int ovf_cnt = 0, stab_err = 0;
    logic stall = 1'b0;

    always #5 clk = ~clk;

    eth_rx_frame_fifo #(.axis_data_width_p(64), .els_p(8), .cnt_width_p(4)) dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .s_axis_tdata_i(s_data), .s_axis_tkeep_i(s_keep), .s_axis_tvalid_i(s_valid),
        .s_axis_tready_o(s_ready), .s_axis_tlast_i(s_last), .s_axis_tuser_i(s_user),
        .m_axis_tdata_o(m_data), .m_axis_tkeep_o(m_keep), .m_axis_tvalid_o(m_valid),
        .m_axis_tready_i(m_ready), .m_axis_tlast_o(m_last), .m_axis_tuser_o(m_user),
        .good_frame_cnt_o(good), .drop_frame_cnt_o(drop), .overflow_o(ovf)
    );

    assign cur = '{data: m_data, keep: m_keep, last: m_last};

    always @(negedge clk) begin
        if (!rst_n) begin
            obs.delete();
            ovf_cnt <= 0;
            stall <= 1'b0;
        end else begin
            if (ovf) ovf_cnt <= ovf_cnt + 1;
            if (stall && m_valid && cur !== held) stab_err <= stab_err + 1;
            stall <= m_valid && !m_ready;
            held <= cur;
            if (m_valid && m_ready) obs.push_back(cur);
        end
    end

    function automatic eth_beat_s mk(input logic [63:0] d, input logic [7:0] k, input logic l);
        return '{data: d, keep: k, last: l};
    endfunction

    task automatic send(input eth_beat_s b, input logic u);
        s_valid = 1'b1; s_data = b.data; s_keep = b.keep; s_last = b.last; s_user = u;
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0; s_user = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        chk += 5;
        if (m_valid !== 1'b0) begin err++; $display("FAIL reset_tvalid got %b want 0", m_valid); end
        if (s_ready !== 1'b0) begin err++; $display("FAIL reset_tready got %b want 0", s_ready); end
        if (good !== 4'h0) begin err++; $display("FAIL reset_good got %h want 0", good); end
        if (drop !== 4'h0) begin err++; $display("FAIL reset_drop got %h want 0", drop); end
        if (ovf !== 1'b0) begin err++; $display("FAIL reset_ovf got %b want 0", ovf); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk++;
        if (s_ready !== 1'b1) begin err++; $display("FAIL post_reset_tready got %b want 1", s_ready); end
    endtask

    task automatic test_good_frame();
        eth_beat_s e[3];
        e[0] = mk(64'h0102_0304_0506_0708, 8'hFF, 1'b0);
        e[1] = mk(64'h1112_1314_1516_1718, 8'hFF, 1'b0);
        e[2] = mk(64'h2122_2324_2526_2728, 8'h0F, 1'b1);
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(e[i], 1'b0);
        repeat (5) @(posedge clk); #1;
        chk += 3;
        if (obs.size() != 3) begin err++; $display("FAIL good_count got %0d want 3", obs.size()); end
        if (good !== 4'd1) begin err++; $display("FAIL good_cnt got %0d want 1", good); end
        if (drop !== 4'd0) begin err++; $display("FAIL good_drop got %0d want 0", drop); end
        for (int i = 0; i < 3 && i < obs.size(); i++) begin
            chk++;
            if (obs[i] !== e[i]) begin err++; $display("FAIL good_beat%0d got %h want %h", i, obs[i], e[i]); end
        end
    endtask

    task automatic test_bad_frame();
        eth_beat_s e[2];
        e[0] = mk(64'hCAFE_0000_0000_0001, 8'hFF, 1'b0);
        e[1] = mk(64'hCAFE_0000_0000_0002, 8'h03, 1'b1);
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(mk(64'hBAD0_0000_0000_0000 + 64'(i), 8'hFF, i == 3), i == 3);
        send(e[0], 1'b0);
        send(e[1], 1'b0);
        repeat (5) @(posedge clk); #1;
        chk += 3;
        if (obs.size() != 2) begin err++; $display("FAIL bad_count got %0d want 2", obs.size()); end
        if (drop !== 4'd1) begin err++; $display("FAIL bad_drop got %0d want 1", drop); end
        if (good !== 4'd1) begin err++; $display("FAIL bad_good got %0d want 1", good); end
        for (int i = 0; i < 2 && i < obs.size(); i++) begin
            chk++;
            if (obs[i] !== e[i]) begin err++; $display("FAIL bad_beat%0d got %h want %h", i, obs[i], e[i]); end
        end
    endtask

    task automatic test_overflow();
        eth_beat_s e[2];
        e[0] = mk(64'h5A5A_0000_0000_0001, 8'hFF, 1'b0);
        e[1] = mk(64'h5A5A_0000_0000_0002, 8'h01, 1'b1);
        do_reset();
        m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) send(mk(64'h0F00_0000_0000_0000 + 64'(i), 8'hFF, 1'b0), 1'b0);
        chk++;
        if (ovf !== 1'b0) begin err++; $display("FAIL ovf_beat8 got %b want 0", ovf); end
        send(mk(64'h0F00_0000_0000_0009, 8'hFF, 1'b0), 1'b0);
        chk++;
        if (ovf !== 1'b1) begin err++; $display("FAIL ovf_beat9 got %b want 1", ovf); end
        send(mk(64'h0F00_0000_0000_000A, 8'hFF, 1'b1), 1'b0);
        chk += 5;
        if (ovf !== 1'b0) begin err++; $display("FAIL ovf_beat10 got %b want 0", ovf); end
        if (ovf_cnt != 1) begin err++; $display("FAIL ovf_pulses got %0d want 1", ovf_cnt); end
        if (m_valid !== 1'b0) begin err++; $display("FAIL ovf_tvalid got %b want 0", m_valid); end
        if (drop !== 4'd1) begin err++; $display("FAIL ovf_drop got %0d want 1", drop); end
        if (good !== 4'd0) begin err++; $display("FAIL ovf_good got %0d want 0", good); end
        send(e[0], 1'b0);
        send(e[1], 1'b0);
        chk++;
        if (m_valid !== 1'b1) begin err++; $display("FAIL ovf_commit_tvalid got %b want 1", m_valid); end
        m_ready = 1'b1;
        repeat (4) @(posedge clk); #1;
        chk += 2;
        if (obs.size() != 2) begin err++; $display("FAIL ovf_count got %0d want 2", obs.size()); end
        if (good !== 4'd1) begin err++; $display("FAIL ovf_good_after got %0d want 1", good); end
        for (int i = 0; i < 2 && i < obs.size(); i++) begin
            chk++;
            if (obs[i] !== e[i]) begin err++; $display("FAIL ovf_beat_out%0d got %h want %h", i, obs[i], e[i]); end
        end
    endtask

    task automatic test_back_to_back();
        eth_beat_s e[4];
        e[0] = mk(64'hAAAA_0000_0000_0001, 8'hFF, 1'b0);
        e[1] = mk(64'hAAAA_0000_0000_0002, 8'h3F, 1'b1);
        e[2] = mk(64'hBBBB_0000_0000_0003, 8'hFF, 1'b0);
        e[3] = mk(64'hBBBB_0000_0000_0004, 8'h07, 1'b1);
        do_reset();
        m_ready = 1'b1;
        fork
            for (int i = 0; i < 4; i++) send(e[i], 1'b0);
            repeat (12) begin
                @(posedge clk); #1;
                m_ready = ~m_ready;
            end
        join
        m_ready = 1'b1;
        repeat (4) @(posedge clk); #1;
        chk += 3;
        if (obs.size() != 4) begin err++; $display("FAIL b2b_count got %0d want 4", obs.size()); end
        if (stab_err != 0) begin err++; $display("FAIL b2b_stable got %0d changes want 0", stab_err); end
        if (good !== 4'd2) begin err++; $display("FAIL b2b_good got %0d want 2", good); end
        for (int i = 0; i < 4 && i < obs.size(); i++) begin
            chk++;
            if (obs[i] !== e[i]) begin err++; $display("FAIL b2b_beat%0d got %h want %h", i, obs[i], e[i]); end
        end
    endtask

    task automatic test_reset_mid();
        eth_beat_s e[2];
        e[0] = mk(64'hD00D_0000_0000_0001, 8'hFF, 1'b0);
        e[1] = mk(64'hD00D_0000_0000_0002, 8'h1F, 1'b1);
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(mk(64'h7700_0000_0000_0000 + 64'(i), 8'hFF, i == 2), 1'b0);
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 m_ready = 1'b0;
        send(mk(64'h8800_0000_0000_0000, 8'hFF, 1'b0), 1'b0);
        chk++;
        if (m_valid !== 1'b1) begin err++; $display("FAIL mid_pre_tvalid got %b want 1", m_valid); end
        #2 rst_n = 1'b0;
        #1;
        chk += 4;
        if (m_valid !== 1'b0) begin err++; $display("FAIL mid_tvalid got %b want 0", m_valid); end
        if (s_ready !== 1'b0) begin err++; $display("FAIL mid_tready got %b want 0", s_ready); end
        if (good !== 4'd0) begin err++; $display("FAIL mid_good got %0d want 0", good); end
        if (drop !== 4'd0) begin err++; $display("FAIL mid_drop got %0d want 0", drop); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b1;
        send(e[0], 1'b0);
        send(e[1], 1'b0);
        repeat (4) @(posedge clk); #1;
        chk += 2;
        if (obs.size() != 2) begin err++; $display("FAIL mid_count got %0d want 2", obs.size()); end
        if (good !== 4'd1) begin err++; $display("FAIL mid_good_after got %0d want 1", good); end
        for (int i = 0; i < 2 && i < obs.size(); i++) begin
            chk++;
            if (obs[i] !== e[i]) begin err++; $display("FAIL mid_beat%0d got %h want %h", i, obs[i], e[i]); end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        m_ready = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            send(mk(64'h5000_0000_0000_0000 + 64'(i), 8'hFF, 1'b1), 1'b0);
            if (i == 14) begin
                chk++;
                if (good !== 4'hE) begin err++; $display("FAIL sat_14 got %h want e", good); end
            end
            if (i == 15) begin
                chk++;
                if (good !== 4'hF) begin err++; $display("FAIL sat_15 got %h want f", good); end
            end
        end
        repeat (4) @(posedge clk); #1;
        chk += 3;
        if (good !== 4'hF) begin err++; $display("FAIL sat_17 got %h want f", good); end
        if (drop !== 4'h0) begin err++; $display("FAIL sat_drop got %h want 0", drop); end
        if (obs.size() != 17) begin err++; $display("FAIL sat_count got %0d want 17", obs.size()); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_frame();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        chk++;
        if (m_user !== 1'b0) begin err++; $display("FAIL tuser got %b want 0", m_user); end
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule
